ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
Parametrised successor to the single-register keyboard scan-code decoder. Consumes the set-2 byte stream from ps2_keyboard and decodes make/break events, including E0-extended keys. Discards the E1 Pause sequence, tracks modifier and Caps-Lock state, optionally filters typematic repeats, and buffers events in a FIFO with a valid/ready handshake toward the CPU/MMIO side.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2
FILTER_REPEAT, 1, 1 = suppress repeated make of the currently held key; 0 = pass every make
PTR_W, $clog2(FIFO_DEPTH), derived pointer width; not overridable

Ports:
clk  in  1  system clock
clrn  in  1  reset, asynchronous, active-low
kb_data  in  8  byte from ps2_keyboard
kb_ready  in  1  ps2_keyboard has a byte
kb_nextdata_n  out  1  pop strobe to ps2_keyboard, active-low
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_data  out  10  {ext, brk, code[7:0]}
ev_overflow  out  1  sticky: event dropped because FIFO full
mod_shift  out  1  LShift(12) or RShift(59) held
mod_ctrl  out  1  LCtrl(14) or RCtrl(E0 14) held
mod_alt  out  1  LAlt(11) or RAlt(E0 11) held
caps_lock  out  1  Caps-Lock toggle state
ev_ascii  out  8  ASCII of head event; present only with KBD_ASCII_EN

Behaviour:
- Reset: clock and reset are as decided: one clock, clk; reset clrn is asynchronous and active-low. While clrn=0:
  - kb_nextdata_n=1; FIFO empty, so ev_valid=0; ev_data=0.
  - ev_overflow=0; all mod_* outputs=0; caps_lock=0; held-key register cleared.
  - Decoder state=IDLE; skip counter=0.
  - Deasserting clrn mid-sequence discards any partial prefix.
- Byte accept: when kb_ready=1 and kb_nextdata_n=1, the byte is accepted. kb_nextdata_n drives 0 for exactly that next cycle, then returns to 1. At most one byte is accepted every 2 cycles.
- Decoder FSM, advanced on accept only:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with counter=7; any other byte -> emit {0,0,b}.
  - EXT: F0 -> EXTBRK; E0 -> stay EXT; any other byte -> emit {1,0,b}, go IDLE.
  - BRK: any byte -> emit {0,1,b}, go IDLE.
  - EXTBRK: any byte -> emit {1,1,b}, go IDLE.
  - SKIP: decrement counter on each accept; go IDLE when it reaches 0. No events are emitted. This consumes the remaining 7 bytes of E1 14 77 E1 F0 14 F0 77.
  - Bytes AA, FA, EE, FE, 00, FF in IDLE are ignored. No event is emitted and the state stays IDLE.
- Repeat filter (FILTER_REPEAT=1):
  - A held register {ext, code} plus a valid bit records the last make.
  - A make equal to the held key is suppressed: no FIFO write and no modifier or caps change.
  - A break of the held key clears the valid bit.
  - A make of a different key replaces the held key.
- Modifiers: each mod_* output is the OR of per-key bits. A make sets the key's bit and a break clears it. Bits update in the accept cycle +1, whether or not the event is written to the FIFO. caps_lock toggles on each unsuppressed make of 58.
- FIFO:
  - The event write is registered one cycle after accept. ev_valid rises on the following cycle, so accept-to-ev_valid latency is 2 cycles.
  - Pop when ev_valid and ev_ready are both 1.
  - Push while full with no pop in the same cycle: the event is dropped and ev_overflow is set. ev_overflow clears only on reset.
  - Push and pop in the same cycle while full: both occur and nothing is dropped.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a PTR_W+1-bit count.
- ev_data holds its value while ev_valid=1 and ev_ready=0.

Optional Feature:
KBD_ASCII_EN.
- Defined:
  - ev_ascii port exists. It is combinationally derived from the head ev_data plus mod_shift and caps_lock as sampled at write time; the ASCII byte is stored in the FIFO alongside the event.
  - Mapped keys: letters A–Z (uppercase when shift XOR caps), digits and their shifted symbols, space (29 -> 20), enter (5A -> 0D), backspace (66 -> 08).
  - Breaks, extended keys and unmapped codes produce 00.
- Undefined: ev_ascii is absent, no ASCII storage and no table logic.

Test Plan:
1. Bytes 1C; F0 1C -> events 0x01C then 0x11C; ev_valid 2 cycles after first accept; kb_nextdata_n low exactly one cycle per byte.
2. E0 75; E0 F0 75 -> events 0x275, 0x375; no event for the prefix bytes.
3. 1C 1C 1C F0 1C with FILTER_REPEAT=1 -> 0x01C, 0x11C only; with FILTER_REPEAT=0 -> three 0x01C then 0x11C.
4. E1 14 77 E1 F0 14 F0 77 1C -> single event 0x01C; mod_ctrl stays 0 throughout.
5. FIFO_DEPTH=4, ev_ready=0, makes 15 1D 24 2D 2C -> 4 entries, ev_overflow=1. Drain gives 015, 01D, 024, 02D in order, then ev_valid=0. Repeat with a push and pop in the same cycle while full -> no drop.
6. 58 F0 58 -> caps_lock=1. With KBD_ASCII_EN: 1C -> ev_ascii 0x41. Then 12 1C -> ev_ascii 0x61 (shift XOR caps). Assert clrn low mid E0 prefix -> all outputs at reset values and next byte 1C yields 0x01C.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scan-code decoder: make/break/E0 events, E1 Pause discard, modifiers,
// optional repeat filter and event FIFO. Define KBD_ASCII_EN to add the ev_ascii output.
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH    = 8,
    parameter int FILTER_REPEAT = 1,
    localparam int PTR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [9:0] ev_data,
    output logic       ev_overflow,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
`ifdef KBD_ASCII_EN
    output logic [7:0] ev_ascii,
`endif
    output logic       caps_lock
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] EXT    = 3'd1;
    localparam logic [2:0] BRK    = 3'd2;
    localparam logic [2:0] EXTBRK = 3'd3;
    localparam logic [2:0] SKIP   = 3'd4;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

`ifdef KBD_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic upper,
                                            input logic shift);
        logic [7:0] letter;
        logic [7:0] res;
        letter = 8'h00;
        res    = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
        // Digits follow shift only; Caps-Lock affects letters alone
        case (code)
            8'h16: res = shift ? 8'h21 : 8'h31;
            8'h1E: res = shift ? 8'h40 : 8'h32;
            8'h26: res = shift ? 8'h23 : 8'h33;
            8'h25: res = shift ? 8'h24 : 8'h34;
            8'h2E: res = shift ? 8'h25 : 8'h35;
            8'h36: res = shift ? 8'h5E : 8'h36;
            8'h3D: res = shift ? 8'h26 : 8'h37;
            8'h3E: res = shift ? 8'h2A : 8'h38;
            8'h46: res = shift ? 8'h28 : 8'h39;
            8'h45: res = shift ? 8'h29 : 8'h30;
            8'h29: res = 8'h20;
            8'h5A: res = 8'h0D;
            8'h66: res = 8'h08;
            default: res = (letter != 8'h00 && upper) ? letter - 8'h20 : letter;
        endcase
        return res;
    endfunction
`endif

    logic       accept;
    logic [2:0] state, next_state;
    logic [2:0] skip_cnt, next_cnt;
    logic       emit;
    logic [9:0] emit_ev;

    assign accept = kb_ready && kb_nextdata_n;

    always_comb begin
        next_state = state;
        next_cnt   = skip_cnt;
        emit       = 1'b0;
        emit_ev    = {2'b00, kb_data};
        case (state)
            IDLE: begin
                if (kb_data == 8'hE0) begin
                    next_state = EXT;
                end else if (kb_data == 8'hF0) begin
                    next_state = BRK;
                end else if (kb_data == 8'hE1) begin
                    next_state = SKIP;
                    next_cnt   = 3'd7;
                end else if (!is_ignored(kb_data)) begin
                    emit = 1'b1;
                end
            end
            EXT: begin
                if (kb_data == 8'hF0) begin
                    next_state = EXTBRK;
                end else if (kb_data != 8'hE0) begin
                    emit       = 1'b1;
                    emit_ev    = {2'b10, kb_data};
                    next_state = IDLE;
                end
            end
            BRK: begin
                emit       = 1'b1;
                emit_ev    = {2'b01, kb_data};
                next_state = IDLE;
            end
            EXTBRK: begin
                emit       = 1'b1;
                emit_ev    = {2'b11, kb_data};
                next_state = IDLE;
            end
            SKIP: begin
                next_cnt = skip_cnt - 3'd1;
                if (skip_cnt <= 3'd1) begin
                    next_state = IDLE;
                    next_cnt   = 3'd0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage p0: accepted byte decoded into a pending event
    logic       vld_p0;
    logic [9:0] ev_p0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state         <= IDLE;
            skip_cnt      <= 3'd0;
            kb_nextdata_n <= 1'b1;
            vld_p0        <= 1'b0;
        end else begin
            kb_nextdata_n <= !accept;
            vld_p0        <= accept && emit;
            if (accept) begin
                state    <= next_state;
                skip_cnt <= next_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ev_p0 <= emit_ev;
    end

    // Stage p1: repeat filter, modifier tracking and FIFO write
    logic       ext_p0, brk_p0;
    logic [7:0] code_p0;
    logic [8:0] held_key;
    logic       held_valid;
    logic       held_match, suppress, push, pop, full, wr;
    logic [5:0] key_down;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [9:0]       ev_mem [FIFO_DEPTH];

    assign ext_p0     = ev_p0[9];
    assign brk_p0     = ev_p0[8];
    assign code_p0    = ev_p0[7:0];
    assign held_match = held_valid && (held_key == {ext_p0, code_p0});
    assign suppress   = (FILTER_REPEAT != 0) && !brk_p0 && held_match;
    assign push       = vld_p0 && !suppress;
    assign full       = (count == DEPTH_C);
    assign ev_valid   = (count != '0);
    assign pop        = ev_valid && ev_ready;
    assign wr         = push && (!full || pop);

    assign mod_shift = key_down[0] | key_down[1];
    assign mod_ctrl  = key_down[2] | key_down[3];
    assign mod_alt   = key_down[4] | key_down[5];
    assign ev_data   = ev_valid ? ev_mem[rd_ptr] : 10'd0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_key    <= 9'd0;
            held_valid  <= 1'b0;
            key_down    <= 6'd0;
            caps_lock   <= 1'b0;
            ev_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (vld_p0 && !suppress) begin
                if (!brk_p0) begin
                    held_key   <= {ext_p0, code_p0};
                    held_valid <= 1'b1;
                end else if (held_match) begin
                    held_valid <= 1'b0;
                end
                case ({ext_p0, code_p0})
                    9'h012: key_down[0] <= !brk_p0;
                    9'h059: key_down[1] <= !brk_p0;
                    9'h014: key_down[2] <= !brk_p0;
                    9'h114: key_down[3] <= !brk_p0;
                    9'h011: key_down[4] <= !brk_p0;
                    9'h111: key_down[5] <= !brk_p0;
                    default: ;
                endcase
                if (!brk_p0 && {ext_p0, code_p0} == 9'h058) caps_lock <= !caps_lock;
            end
            if (push && full && !pop) ev_overflow <= 1'b1;
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) ev_mem[wr_ptr] <= ev_p0;
    end

`ifdef KBD_ASCII_EN
    logic [7:0] asc_p0;
    logic [7:0] asc_mem [FIFO_DEPTH];

    assign asc_p0   = (ext_p0 || brk_p0) ? 8'h00 :
                      to_ascii(code_p0, mod_shift ^ caps_lock, mod_shift);
    assign ev_ascii = ev_valid ? asc_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr) asc_mem[wr_ptr] <= asc_p0;
    end
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: three decoder instances (filtered depth 8, unfiltered depth 8,
// filtered depth 4) fed one shared PS/2 byte stream.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       rdy_a, rdy_b, rdy_c;

    logic       nd_a, v_a, ov_a, sh_a, ct_a, al_a, cp_a;
    logic       nd_b, v_b, ov_b, sh_b, ct_b, al_b, cp_b;
    logic       nd_c, v_c, ov_c, sh_c, ct_c, al_c, cp_c;
    logic [9:0] d_a, d_b, d_c;
`ifdef KBD_ASCII_EN
    logic [7:0] as_a, as_b, as_c;
`endif

    always #5 clk = ~clk;

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .FILTER_REPEAT(1)) dut_a (
        .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(nd_a), .ev_valid(v_a), .ev_ready(rdy_a), .ev_data(d_a),
        .ev_overflow(ov_a), .mod_shift(sh_a), .mod_ctrl(ct_a), .mod_alt(al_a),
`ifdef KBD_ASCII_EN
        .ev_ascii(as_a),
`endif
        .caps_lock(cp_a));

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .FILTER_REPEAT(0)) dut_b (
        .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(nd_b), .ev_valid(v_b), .ev_ready(rdy_b), .ev_data(d_b),
        .ev_overflow(ov_b), .mod_shift(sh_b), .mod_ctrl(ct_b), .mod_alt(al_b),
`ifdef KBD_ASCII_EN
        .ev_ascii(as_b),
`endif
        .caps_lock(cp_b));

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .FILTER_REPEAT(1)) dut_c (
        .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(nd_c), .ev_valid(v_c), .ev_ready(rdy_c), .ev_data(d_c),
        .ev_overflow(ov_c), .mod_shift(sh_c), .mod_ctrl(ct_c), .mod_alt(al_c),
`ifdef KBD_ASCII_EN
        .ev_ascii(as_c),
`endif
        .caps_lock(cp_c));

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [9:0] d;
        logic [3:0] m;
        logic [7:0] asc;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic [7:0] b, input logic v, input logic [9:0] d,
                                input logic [3:0] m, input logic [7:0] asc);
        vec_t r;
        r.b = b; r.v = v; r.d = d; r.m = m; r.asc = asc;
        vq.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    // Returns on the negedge two cycles after the accepting edge
    task automatic send(input logic [7:0] b, input logic pop_c);
        @(negedge clk);
        kb_data  = b;
        kb_ready = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0;
        if (pop_c) rdy_c = 1'b1;
        @(negedge clk);
        if (pop_c) rdy_c = 1'b0;
    endtask

    task automatic pop(input int which);
        @(negedge clk);
        if (which == 0) rdy_a = 1'b1;
        if (which == 1) rdy_b = 1'b1;
        if (which == 2) rdy_c = 1'b1;
        @(negedge clk);
        if (which == 0) rdy_a = 1'b0;
        if (which == 1) rdy_b = 1'b0;
        if (which == 2) rdy_c = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_b [4];
        logic [9:0] exp_c [4];
        clrn = 1'b0; kb_data = 8'h00; kb_ready = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b1; rdy_c = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_nextdata_n", nd_a, 1);
        chk("rst_ev_valid", v_a, 0);
        chk("rst_ev_data", d_a, 0);
        chk("rst_flags", {ov_a, sh_a, ct_a, al_a, cp_a}, 0);
        clrn = 1'b1;

        // Byte handshake and two-cycle event latency
        @(negedge clk);
        kb_data = 8'h1C; kb_ready = 1'b1;
        @(negedge clk);
        chk("nextdata_low", nd_a, 0);
        chk("latency_1cyc_valid", v_a, 0);
        @(negedge clk);
        kb_ready = 1'b0;
        chk("nextdata_high", nd_a, 1);
        chk("latency_2cyc_valid", v_a, 1);
        chk("latency_2cyc_data", d_a, 10'h01C);
        @(negedge clk);
        chk("no_second_accept", v_a, 1);
        pop(0);
        chk("single_event_only", v_a, 0);

        // Directed vector table, filtered depth-8 instance
        add(8'h1C, 1, 10'h01C, 4'b0000, 8'h61);
        add(8'hF0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h1C, 1, 10'h11C, 4'b0000, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h75, 1, 10'h275, 4'b0000, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h75, 1, 10'h375, 4'b0000, 8'h00);
        add(8'hE1, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h14, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h77, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hE1, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h14, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h77, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h1C, 1, 10'h01C, 4'b0000, 8'h61);
        add(8'h1C, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h1C, 1, 10'h11C, 4'b0000, 8'h00);
        add(8'hAA, 0, 10'h000, 4'b0000, 8'h00);
        add(8'hFA, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h00, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h12, 1, 10'h012, 4'b1000, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b1000, 8'h00);
        add(8'h14, 1, 10'h214, 4'b1100, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b1100, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b1100, 8'h00);
        add(8'h14, 1, 10'h314, 4'b1000, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b1000, 8'h00);
        add(8'h12, 1, 10'h112, 4'b0000, 8'h00);
        add(8'h11, 1, 10'h011, 4'b0010, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0010, 8'h00);
        add(8'h11, 1, 10'h111, 4'b0000, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b0000, 8'h00);
        add(8'h11, 1, 10'h211, 4'b0010, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b0010, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0010, 8'h00);
        add(8'h11, 1, 10'h311, 4'b0000, 8'h00);
        add(8'h58, 1, 10'h058, 4'b0001, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b0001, 8'h00);
        add(8'h58, 1, 10'h158, 4'b0001, 8'h00);
        add(8'h59, 1, 10'h059, 4'b1001, 8'h00);
        add(8'hF0, 0, 10'h000, 4'b1001, 8'h00);
        add(8'h59, 1, 10'h159, 4'b0001, 8'h00);
        add(8'h1C, 1, 10'h01C, 4'b0001, 8'h41);
        add(8'h12, 1, 10'h012, 4'b1001, 8'h00);
        add(8'h1C, 1, 10'h01C, 4'b1001, 8'h61);
        add(8'h16, 1, 10'h016, 4'b1001, 8'h21);
        add(8'hF0, 0, 10'h000, 4'b1001, 8'h00);
        add(8'h12, 1, 10'h112, 4'b0001, 8'h00);
        add(8'h29, 1, 10'h029, 4'b0001, 8'h20);
        add(8'h5A, 1, 10'h05A, 4'b0001, 8'h0D);
        add(8'h66, 1, 10'h066, 4'b0001, 8'h08);
        add(8'hE0, 0, 10'h000, 4'b0001, 8'h00);
        add(8'hE0, 0, 10'h000, 4'b0001, 8'h00);
        add(8'h74, 1, 10'h274, 4'b0001, 8'h00);

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            send(vq[i].b, 1'b0);
            chk($sformatf("vec%0d_valid", i), v_a, vq[i].v);
            chk($sformatf("vec%0d_mods", i), {sh_a, ct_a, al_a, cp_a}, vq[i].m);
            if (vq[i].v) begin
                chk($sformatf("vec%0d_data", i), d_a, vq[i].d);
`ifdef KBD_ASCII_EN
                chk($sformatf("vec%0d_ascii", i), as_a, vq[i].asc);
`endif
                pop(0);
            end
        end
        chk("tbl_no_overflow", ov_a, 0);

        // Typematic repeat: filtered vs unfiltered instance
        do_reset();
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b1;
        send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        exp_b[0] = 10'h01C; exp_b[1] = 10'h01C; exp_b[2] = 10'h01C; exp_b[3] = 10'h11C;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("nofilt%0d_valid", i), v_b, 1);
            chk($sformatf("nofilt%0d_data", i), d_b, exp_b[i]);
            pop(1);
        end
        chk("nofilt_empty", v_b, 0);
        chk("filt0_data", d_a, 10'h01C);
        pop(0);
        chk("filt1_data", d_a, 10'h11C);
        pop(0);
        chk("filt_empty", v_a, 0);

        // Depth-4 FIFO overflow and ordered drain
        do_reset();
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b0;
        send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        chk("full_no_overflow_yet", ov_c, 0);
        send(8'h2C, 1'b0);
        chk("overflow_set", ov_c, 1);
        exp_c[0] = 10'h015; exp_c[1] = 10'h01D; exp_c[2] = 10'h024; exp_c[3] = 10'h02D;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), v_c, 1);
            chk($sformatf("drain%0d_data", i), d_c, exp_c[i]);
            pop(2);
        end
        chk("drain_empty", v_c, 0);
        chk("overflow_sticky", ov_c, 1);

        // Push and pop in the same cycle while full
        do_reset();
        chk("overflow_cleared", ov_c, 0);
        send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        @(negedge clk);
        chk("hold_while_stalled", d_c, 10'h015);
        send(8'h2C, 1'b1);
        chk("pushpop_no_overflow", ov_c, 0);
        exp_c[0] = 10'h01D; exp_c[1] = 10'h024; exp_c[2] = 10'h02D; exp_c[3] = 10'h02C;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain%0d_valid", i), v_c, 1);
            chk($sformatf("pp_drain%0d_data", i), d_c, exp_c[i]);
            pop(2);
        end
        chk("pp_drain_empty", v_c, 0);

        // Asynchronous reset in the middle of an E0 prefix
        rdy_a = 1'b0; rdy_b = 1'b1; rdy_c = 1'b1;
        send(8'h12, 1'b0); send(8'h58, 1'b0); send(8'hE0, 1'b0);
        chk("pre_rst_state", {v_a, sh_a, cp_a}, 3'b111);
        #2;
        clrn = 1'b0;
        #1;
        chk("async_rst_valid", v_a, 0);
        chk("async_rst_data", d_a, 0);
        chk("async_rst_flags", {ov_a, sh_a, ct_a, al_a, cp_a}, 0);
        chk("async_rst_nextdata", nd_a, 1);
        @(negedge clk);
        clrn = 1'b1;
        send(8'h1C, 1'b0);
        chk("post_rst_valid", v_a, 1);
        chk("post_rst_data", d_a, 10'h01C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
